// File: rtl/tinyalu_pkg.sv
// -----------------------------------------------------------------------------
// tinyalu_pkg
// Shared types for the TinyALU command issuer: operation encoding, operand and
// result widths, and the queued command record.
// -----------------------------------------------------------------------------
package tinyalu_pkg;

  localparam int OP_W      = 3;
  localparam int OPERAND_W = 8;
  localparam int RESULT_W  = 16;

  typedef enum logic [OP_W-1:0] {
    no_op  = 3'd0,
    add_op = 3'd1,
    and_op = 3'd2,
    xor_op = 3'd3,
    mul_op = 3'd4
  } alu_op_e;

  typedef struct packed {
    alu_op_e              op;
    logic [OPERAND_W-1:0] a;
    logic [OPERAND_W-1:0] b;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// -----------------------------------------------------------------------------
// alu_cmd_fifo
// DEPTH-entry synchronous FIFO of alu_cmd_t records. Pushes are refused while
// full even if a pop happens in the same cycle; a pushed entry is visible at
// the head no earlier than the cycle after the push.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous active-high reset (empties the queue)
//   push_i      write request (ignored when full_o)
//   push_data_i command to write
//   pop_i       read request (ignored when empty_o)
//   pop_data_o  head entry
//   full_o      queue holds DEPTH entries
//   empty_o     queue holds no entries
// -----------------------------------------------------------------------------
module alu_cmd_fifo
  import tinyalu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push_i,
  input  alu_cmd_t push_data_i,
  input  logic     pop_i,
  output alu_cmd_t pop_data_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  alu_cmd_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define which entries are valid, and a reset-free array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// -----------------------------------------------------------------------------
// alu_cmd_issuer
// Queues ALU commands and issues them one at a time to a TinyALU, waiting for
// alu_done (bounded by TIMEOUT cycles) and returning a one-cycle response.
// no_op commands are answered directly with result 0 and never reach the ALU.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake (cmd_ready = queue not full)
//   cmd_op, cmd_a, cmd_b       command operation and operands
//   alu_start, alu_op/a/b      TinyALU request (op/a/b read 0 while idle)
//   alu_done, alu_result       TinyALU completion and result
//   rsp_valid                  one-cycle response strobe, no backpressure
//   rsp_result/op/timeout      response payload
//   stat_issued, stat_timeouts saturating counters, only when
//                              TINYALU_CMD_STATS_EN is defined
// -----------------------------------------------------------------------------
module alu_cmd_issuer
  import tinyalu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [OPERAND_W-1:0] cmd_a,
  input  logic [OPERAND_W-1:0] cmd_b,
  input  logic [OP_W-1:0]      cmd_op,
  output logic                 alu_start,
  output logic [OP_W-1:0]      alu_op,
  output logic [OPERAND_W-1:0] alu_a,
  output logic [OPERAND_W-1:0] alu_b,
  input  logic                 alu_done,
  input  logic [RESULT_W-1:0]  alu_result,
  output logic                 rsp_valid,
  output logic [RESULT_W-1:0]  rsp_result,
  output logic [OP_W-1:0]      rsp_op,
  output logic                 rsp_timeout
`ifdef TINYALU_CMD_STATS_EN
  ,
  output logic [15:0]          stat_issued,
  output logic [15:0]          stat_timeouts
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e               state_q;
  alu_op_e              hold_op_q;
  logic [TMO_W-1:0]     tmo_cnt_q;
  logic                 alu_start_q;
  logic [OP_W-1:0]      alu_op_q;
  logic [OPERAND_W-1:0] alu_a_q;
  logic [OPERAND_W-1:0] alu_b_q;
  logic                 rsp_valid_q;
  logic [RESULT_W-1:0]  rsp_result_q;
  logic [OP_W-1:0]      rsp_op_q;
  logic                 rsp_timeout_q;

  alu_cmd_t push_cmd;
  alu_cmd_t head_cmd;
  logic     fifo_full;
  logic     fifo_empty;
  logic     pop;

  assign push_cmd  = '{op: alu_op_e'(cmd_op), a: cmd_a, b: cmd_b};
  assign cmd_ready = !fifo_full;
  assign pop       = (state_q == IDLE) && !fifo_empty;

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (cmd_valid),
    .push_data_i(push_cmd),
    .pop_i      (pop),
    .pop_data_o (head_cmd),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      hold_op_q     <= no_op;
      tmo_cnt_q     <= '0;
      alu_start_q   <= 1'b0;
      alu_op_q      <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_op_q      <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            hold_op_q <= head_cmd.op;
            if (head_cmd.op == no_op) begin
              rsp_valid_q   <= 1'b1;
              rsp_result_q  <= '0;
              rsp_op_q      <= no_op;
              rsp_timeout_q <= 1'b0;
              state_q       <= RESP;
            end else begin
              // Request goes out with the transition so it is already
              // visible to the ALU throughout ISSUE.
              alu_start_q <= 1'b1;
              alu_op_q    <= head_cmd.op;
              alu_a_q     <= head_cmd.a;
              alu_b_q     <= head_cmd.b;
              state_q     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          tmo_cnt_q <= '0;
          state_q   <= WAIT;
        end
        WAIT: begin
          // alu_done wins over a timeout expiring in the same cycle.
          if (alu_done || (tmo_cnt_q == TMO_LAST)) begin
            alu_start_q   <= 1'b0;
            alu_op_q      <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            rsp_valid_q   <= 1'b1;
            rsp_result_q  <= alu_done ? alu_result : '0;
            rsp_op_q      <= hold_op_q;
            rsp_timeout_q <= !alu_done;
            state_q       <= RESP;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_start   = alu_start_q;
  assign alu_op      = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_op      = rsp_op_q;
  assign rsp_timeout = rsp_timeout_q;

`ifdef TINYALU_CMD_STATS_EN
  logic        issue_evt;
  logic        tmo_evt;
  logic [15:0] stat_issued_q;
  logic [15:0] stat_timeouts_q;

  assign issue_evt = pop && (head_cmd.op != no_op);
  assign tmo_evt   = (state_q == WAIT) && !alu_done && (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_issued_q   <= '0;
      stat_timeouts_q <= '0;
    end else begin
      if (issue_evt && (stat_issued_q != 16'hFFFF))
        stat_issued_q <= stat_issued_q + 16'd1;
      if (tmo_evt && (stat_timeouts_q != 16'hFFFF))
        stat_timeouts_q <= stat_timeouts_q + 16'd1;
    end
  end

  assign stat_issued   = stat_issued_q;
  assign stat_timeouts = stat_timeouts_q;
`else
  // Statistics disabled: no counters and no stat ports are built.
`endif

endmodule
